// File: rtl/run_sequencer.sv
// Purpose : launches one run of an external FSM: holds its reset, starts it,
//           waits for a ready edge (or a timeout) and reports the result.
// Latency : go -> RST_CYC cycles of dut_reset -> up to TIMEOUT RUN cycles -> 1-cycle done.
// Flow    : no backpressure; go is accepted only in IDLE and is dropped otherwise.
// Ports   : clk_p/reset (sync, active-high); go/expected from host;
//           dut_reset/dut_start to the FSM, dut_ready/dut_out from it;
//           busy/done/correct/timed_out/cycles status back to the host.
module run_sequencer #(
  parameter int OUT_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter int RST_CYC = 2
) (
  input  logic             clk_p,
  input  logic             reset,
  input  logic             go,
  input  logic [OUT_W-1:0] expected,
  output logic             dut_reset,
  output logic             dut_start,
  input  logic             dut_ready,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             correct,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRST   = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam int               RC_W     = $clog2(RST_CYC + 1);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [CNT_W-1:0] r_run_cnt;
  logic [CNT_W-1:0] w_run_k;
  logic             r_ready_q;
  logic             w_ready_evt;
  logic             w_timeout;
  logic [OUT_W-1:0] r_exp;
  logic             r_start;
  logic             r_correct;
  logic             r_timed_out;
  logic [CNT_W-1:0] r_cycles;

  // w_run_k is the 1-based index of the RUN cycle currently in progress.
  assign w_run_k     = r_run_cnt + CNT_W'(1);
  assign w_ready_evt = (r_state == S_RUN) && dut_ready && !r_ready_q;
  assign w_timeout   = (r_state == S_RUN) && (w_run_k == TO_VAL);

  // State register.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (go) w_next = S_DRST;
      S_DRST:   if (r_rst_cnt == RST_LAST) w_next = S_RUN;
      S_RUN:    if (w_ready_evt || w_timeout) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: counters, edge detector, latched golden value and results.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      r_rst_cnt   <= '0;
      r_run_cnt   <= '0;
      r_ready_q   <= 1'b0;
      r_exp       <= '0;
      r_start     <= 1'b0;
      r_correct   <= 1'b0;
      r_timed_out <= 1'b0;
      r_cycles    <= '0;
    end else begin
      // Registered from next state so dut_start is high exactly in RUN.
      r_start <= (w_next == S_RUN);
      case (r_state)
        S_IDLE: begin
          r_rst_cnt <= '0;
          if (go) begin
            r_exp       <= expected;
            r_correct   <= 1'b0;
            r_timed_out <= 1'b0;
            r_cycles    <= '0;
          end
        end
        S_DRST: begin
          r_rst_cnt <= r_rst_cnt + 1'b1;
          r_run_cnt <= '0;
          // A ready level left over from the previous run must not count as an edge.
          r_ready_q <= 1'b0;
        end
        S_RUN: begin
          r_ready_q <= dut_ready;
          r_run_cnt <= w_run_k;
          // Ready wins over a coincident timeout.
          if (w_ready_evt) begin
            r_cycles  <= w_run_k;
            r_correct <= (dut_out == r_exp);
          end else if (w_timeout) begin
            r_cycles    <= TO_VAL;
            r_correct   <= 1'b0;
            r_timed_out <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FSM reset follows the sequencer reset combinationally.
  assign dut_reset = reset | (r_state == S_DRST);
  assign dut_start = r_start;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_REPORT);
  assign correct   = r_correct;
  assign timed_out = r_timed_out;
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  localparam int OUT_W = 5;
  localparam int CNT_W = 16;
  localparam int RST   = 2;
  localparam int TO0   = 1000;
  localparam int TO1   = 20;

  logic clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  logic             reset_i [2];
  logic             go_i    [2];
  logic [OUT_W-1:0] exp_i   [2];
  logic [OUT_W-1:0] out_i   [2];
  logic             rdy_i   [2] = '{1'b0, 1'b0};

  logic             dut_reset_o [2];
  logic             dut_start_o [2];
  logic             busy_o      [2];
  logic             done_o      [2];
  logic             correct_o   [2];
  logic             timed_out_o [2];
  logic [CNT_W-1:0] cycles_o    [2];

  run_sequencer u_dut0 (
    .clk_p(clk_p), .reset(reset_i[0]), .go(go_i[0]), .expected(exp_i[0]),
    .dut_reset(dut_reset_o[0]), .dut_start(dut_start_o[0]),
    .dut_ready(rdy_i[0]), .dut_out(out_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .correct(correct_o[0]),
    .timed_out(timed_out_o[0]), .cycles(cycles_o[0])
  );

  run_sequencer #(.TIMEOUT(TO1)) u_dut1 (
    .clk_p(clk_p), .reset(reset_i[1]), .go(go_i[1]), .expected(exp_i[1]),
    .dut_reset(dut_reset_o[1]), .dut_start(dut_start_o[1]),
    .dut_ready(rdy_i[1]), .dut_out(out_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .correct(correct_o[1]),
    .timed_out(timed_out_o[1]), .cycles(cycles_o[1])
  );

  // Sequenced-FSM stand-in: raises ready on its ready_at-th started cycle
  // (0 = never); with tog set, ready toggles whenever it is not started.
  int ready_at [2] = '{0, 0};
  bit tog      [2] = '{1'b0, 1'b0};
  int rc       [2] = '{0, 0};

  always @(negedge clk_p) begin
    for (int i = 0; i < 2; i++) begin
      if (dut_reset_o[i] === 1'b1) begin
        rc[i]    = 0;
        rdy_i[i] = 1'b0;
      end else if (dut_start_o[i] === 1'b1) begin
        rc[i] = rc[i] + 1;
        if (ready_at[i] != 0 && rc[i] >= ready_at[i]) rdy_i[i] = 1'b1;
      end else if (tog[i]) begin
        rdy_i[i] = ~rdy_i[i];
      end
    end
  end

  // Run-level model: m_t counts cycles since go was accepted (-1 = idle).
  // Cycles 1..RST hold the FSM in reset, the next K cycles run it, then one
  // report cycle. K and the result are decided at launch from the FSM profile.
  int m_t     [2] = '{-1, -1};
  int m_k     [2] = '{0, 0};
  bit m_pto   [2];
  bit m_pc    [2];
  bit m_corr  [2] = '{1'b0, 1'b0};
  bit m_to    [2] = '{1'b0, 1'b0};
  int m_cyc   [2] = '{0, 0};
  bit m_armed [2] = '{1'b0, 1'b0};

  always @(posedge clk_p) begin
    for (int i = 0; i < 2; i++) begin
      int tmo;
      tmo = (i == 0) ? TO0 : TO1;
      if (reset_i[i]) begin
        m_t[i] = -1; m_corr[i] = 0; m_to[i] = 0; m_cyc[i] = 0; m_armed[i] = 1;
      end else if (m_t[i] < 0) begin
        if (go_i[i]) begin
          m_t[i] = 1; m_corr[i] = 0; m_to[i] = 0; m_cyc[i] = 0;
          if (ready_at[i] >= 1 && ready_at[i] <= tmo) begin
            m_k[i] = ready_at[i]; m_pto[i] = 0; m_pc[i] = (out_i[i] == exp_i[i]);
          end else begin
            m_k[i] = tmo; m_pto[i] = 1; m_pc[i] = 0;
          end
        end
      end else begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == RST + m_k[i] + 1) begin
          m_cyc[i] = m_k[i]; m_corr[i] = m_pc[i]; m_to[i] = m_pto[i];
        end else if (m_t[i] == RST + m_k[i] + 2) begin
          m_t[i] = -1;
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int done_cnt  [2] = '{0, 0};
  int drst_cnt  [2] = '{0, 0};
  int start_cnt [2] = '{0, 0};

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_p);
      for (int i = 0; i < 2; i++) begin
        if (m_armed[i]) begin
          int t, k;
          t = m_t[i];
          k = m_k[i];
          chk($sformatf("u%0d.busy", i), busy_o[i], (t >= 1));
          chk($sformatf("u%0d.done", i), done_o[i], (t == RST + k + 1));
          chk($sformatf("u%0d.dut_start", i), dut_start_o[i], (t > RST && t <= RST + k));
          chk($sformatf("u%0d.dut_reset", i), dut_reset_o[i],
              (reset_i[i] || (t >= 1 && t <= RST)));
          chk($sformatf("u%0d.correct", i), correct_o[i], m_corr[i]);
          chk($sformatf("u%0d.timed_out", i), timed_out_o[i], m_to[i]);
          chk($sformatf("u%0d.cycles", i), cycles_o[i], m_cyc[i]);
          if (done_o[i] === 1'b1) done_cnt[i]++;
          if (dut_start_o[i] === 1'b1) start_cnt[i]++;
          if (dut_reset_o[i] === 1'b1 && !reset_i[i]) drst_cnt[i]++;
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_p);
      #2;
    end
  endtask

  task automatic launch(input int i, input int e, input int o, input int rat, input bit tg);
    exp_i[i]    = OUT_W'(e);
    out_i[i]    = OUT_W'(o);
    ready_at[i] = rat;
    tog[i]      = tg;
    go_i[i]     = 1'b1;
    step(1);
    go_i[i]     = 1'b0;
  endtask

  task automatic wait_done(input int i, input string nm, input int budget);
    int n;
    n = 0;
    while (done_o[i] !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk({nm, "_done_seen"}, (done_o[i] === 1'b1), 1);
  endtask

  task automatic wait_start(input int i, input int cnt, input int budget);
    int n, s;
    n = 0;
    s = 0;
    while (s < cnt && n < budget) begin
      step(1);
      n++;
      if (dut_start_o[i] === 1'b1) s++;
    end
    chk("wait_start_reached", s, cnt);
  endtask

  int d0, r0, s0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_i[i] = 1'b1; go_i[i] = 1'b0; exp_i[i] = '0; out_i[i] = '0;
    end
    fork
      monitor();
    join_none
    step(3);
    reset_i[0] = 1'b0;
    reset_i[1] = 1'b0;
    step(1);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_cycles", cycles_o[0], 0);

    // Basic run: ready on RUN cycle 7, matching output.
    d0 = done_cnt[0]; r0 = drst_cnt[0]; s0 = start_cnt[0];
    launch(0, 9, 9, 7, 0);
    wait_done(0, "t_match", 100);
    chk("t_match_cycles", cycles_o[0], 7);
    chk("t_match_correct", correct_o[0], 1);
    chk("t_match_timed_out", timed_out_o[0], 0);
    step(3);
    chk("t_match_done_pulses", done_cnt[0] - d0, 1);
    chk("t_match_dut_reset_len", drst_cnt[0] - r0, 2);
    chk("t_match_start_len", start_cnt[0] - s0, 7);

    // Mismatching output.
    launch(0, 9, 8, 7, 0);
    wait_done(0, "t_mism", 100);
    chk("t_mism_correct", correct_o[0], 0);
    chk("t_mism_cycles", cycles_o[0], 7);
    step(3);
    chk("t_mism_hold_correct", correct_o[0], 0);

    // Ready on the first RUN cycle, then toggling afterwards.
    launch(0, 21, 21, 1, 1);
    wait_done(0, "t_first", 100);
    chk("t_first_cycles", cycles_o[0], 1);
    step(6);
    chk("t_first_hold_cycles", cycles_o[0], 1);
    chk("t_first_hold_correct", correct_o[0], 1);
    tog[0] = 1'b0;

    // go pulsed in RUN and in REPORT must be ignored.
    d0 = done_cnt[0];
    launch(0, 3, 3, 5, 0);
    wait_start(0, 2, 50);
    go_i[0] = 1'b1; step(1); go_i[0] = 1'b0;
    wait_done(0, "t_ign", 100);
    go_i[0] = 1'b1; step(1); go_i[0] = 1'b0;
    step(8);
    chk("t_ign_done_pulses", done_cnt[0] - d0, 1);
    chk("t_ign_busy", busy_o[0], 0);
    chk("t_ign_cycles", cycles_o[0], 5);

    // Sequencer reset in RUN cycle 3.
    d0 = done_cnt[0];
    launch(0, 1, 1, 10, 0);
    wait_start(0, 3, 50);
    reset_i[0] = 1'b1;
    step(1);
    chk("t_rst_busy", busy_o[0], 0);
    chk("t_rst_start", dut_start_o[0], 0);
    chk("t_rst_dut_reset", dut_reset_o[0], 1);
    chk("t_rst_cycles", cycles_o[0], 0);
    reset_i[0] = 1'b0;
    step(15);
    chk("t_rst_no_done", done_cnt[0] - d0, 0);

    // Reset beats go in the same cycle.
    reset_i[0] = 1'b1; go_i[0] = 1'b1;
    step(1);
    reset_i[0] = 1'b0; go_i[0] = 1'b0;
    step(1);
    chk("t_prio_busy", busy_o[0], 0);

    // TIMEOUT=20, ready never rises.
    s0 = start_cnt[1];
    launch(1, 4, 4, 0, 0);
    wait_done(1, "t_to", 100);
    chk("t_to_timed_out", timed_out_o[1], 1);
    chk("t_to_correct", correct_o[1], 0);
    chk("t_to_cycles", cycles_o[1], 20);
    chk("t_to_start_len", start_cnt[1] - s0, 20);
    step(2);

    // Ready on RUN cycle 20 coincides with the timeout: ready wins.
    launch(1, 17, 17, 20, 0);
    wait_done(1, "t_tie", 100);
    chk("t_tie_timed_out", timed_out_o[1], 0);
    chk("t_tie_cycles", cycles_o[1], 20);
    chk("t_tie_correct", correct_o[1], 1);
    step(2);

    // Ready one cycle too late: timeout even though the value would match.
    launch(1, 4, 4, 21, 0);
    wait_done(1, "t_late", 100);
    chk("t_late_timed_out", timed_out_o[1], 1);
    chk("t_late_correct", correct_o[1], 0);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL take parameter OUT_W, default 5: width of the sequenced FSM's result bus.
REQ-002 SHALL take parameter CNT_W, default 16: cycle-counter width.
REQ-003 SHALL take parameter TIMEOUT, default 1000: maximum RUN cycles before abort (1 <= TIMEOUT <= 2^CNT_W-1).
REQ-004 SHALL take parameter RST_CYC, default 2: cycles the FSM reset is held (>= 1).
REQ-005 SHALL have port clk_p, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port go, input, 1 bit: host request to launch one run.
REQ-008 SHALL have port expected, input, OUT_W bits: golden result, sampled when go is accepted.
REQ-009 SHALL have port dut_reset, output, 1 bit: reset to the sequenced FSM.
REQ-010 SHALL have port dut_start, output, 1 bit: start to the sequenced FSM.
REQ-011 SHALL have port dut_ready, input, 1 bit: completion flag from the FSM.
REQ-012 SHALL have port dut_out, input, OUT_W bits: result bus from the FSM.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port correct, output, 1 bit: result matched expected.
REQ-016 SHALL have port timed_out, output, 1 bit: run aborted by timeout.
REQ-017 SHALL have port cycles, output, CNT_W bits: RUN-cycle count of the last run.

Function
REQ-018 SHALL implement states IDLE, DRST, RUN and REPORT with a registered state variable.
REQ-019 IDLE: go=1 SHALL latch expected, clear correct, timed_out and cycles, and enter DRST next cycle.
REQ-020 go SHALL be ignored in every state except IDLE, with no queuing.
REQ-021 DRST: dut_reset SHALL be 1 for exactly RST_CYC cycles, then the block SHALL enter RUN.
REQ-022 dut_reset SHALL equal reset OR (state==DRST), combinational, so an FSM reset follows the sequencer reset.
REQ-023 dut_start SHALL be 1 only while the state is RUN, registered.
REQ-024 The ready-edge register ready_q SHALL be cleared in DRST.
REQ-025 In RUN, a ready event SHALL be defined as dut_ready=1 AND ready_q=0.
REQ-026 The RUN counter SHALL be 0 on RUN entry and increment by 1 every RUN cycle.
REQ-027 On a ready event at RUN cycle k (k=1 is the first RUN cycle), the block SHALL capture cycles=k and correct=(dut_out==expected latched), and enter REPORT.
REQ-028 If TIMEOUT RUN cycles elapse with no ready event, the block SHALL set timed_out=1, correct=0, cycles=TIMEOUT, and enter REPORT.
REQ-029 If a ready event and the timeout fall in the same cycle, the ready event SHALL win and timed_out SHALL stay 0.
REQ-030 REPORT SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-031 correct, timed_out and cycles SHALL hold until the next accepted go.
REQ-032 Comparison SHALL be bitwise over OUT_W bits; the counter SHALL never wrap, because TIMEOUT bounds it.
REQ-033 dut_ready falling or toggling after the ready event SHALL have no effect.

Reset
REQ-034 When reset=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-run.
REQ-035 Under that reset, outputs SHALL be dut_start=0, busy=0, done=0, correct=0, timed_out=0, cycles=0, with ready_q=0 and the counters=0.
REQ-036 reset SHALL take priority over go in the same cycle.

Verification
REQ-037 Defaults; go=1 with expected=5'd9; FSM model raises ready 7 cycles after start with out=9 -> dut_reset high 2 cycles, then dut_start; done pulses once; cycles=7, correct=1, timed_out=0.
REQ-038 Same run with out=5'd8 -> done pulse, correct=0, timed_out=0, cycles=7.
REQ-039 TIMEOUT=20 and ready never rises -> done on the cycle after the 20th RUN cycle; timed_out=1, correct=0, cycles=20.
REQ-040 TIMEOUT=20 and ready rises on RUN cycle 20 -> timed_out=0, cycles=20, correct per compare.
REQ-041 reset=1 at RUN cycle 3 -> next cycle IDLE, dut_start=0, dut_reset=1 during reset, all outputs 0, no done pulse.
REQ-042 go pulsed during RUN and REPORT -> ignored; exactly one done pulse per accepted go; busy low only in IDLE.
